regbank_mp: RTL and testbench
=============================

Name: regbank_mp

Overview:
- Parametrised successor to the 16x16 register bank: DEPTH x WIDTH storage, one write port and two independent read ports (A, B).
- Registered read data with a per-port valid strobe.
- Built-in sequential clear engine that sweeps every entry to zero after reset or on request.
- Sits between the writeback mux and the ALU operand latches in the datapath.

Parameters:
WIDTH, 16, data bits per entry
DEPTH, 16, number of entries; power of two, >= 2
AW, $clog2(DEPTH), address width (derived; not overridden)

Ports:
CLK  in  1  single clock; all state updates on posedge
RST_N  in  1  asynchronous, active-low reset
clr_req  in  1  level; sampled in IDLE, starts a full clear sweep
busy  out  1  high while the clear sweep runs
wr_en  in  1  write strobe, sampled on posedge
wr_addr  in  AW  write address
wr_data  in  WIDTH  write data
rd_a_en  in  1  port A read strobe
rd_a_addr  in  AW  port A address
rd_a_data  out  WIDTH  port A registered data
rd_a_valid  out  1  one-cycle pulse: rd_a_data updated
rd_b_en  in  1  port B read strobe
rd_b_addr  in  AW  port B address
rd_b_data  out  WIDTH  port B registered data
rd_b_valid  out  1  one-cycle pulse: rd_b_data updated

Behaviour:
- Reset (RST_N low, asynchronous):
  - Outputs: rd_a_data = rd_b_data = 0, rd_*_valid = 0, busy = 1.
  - FSM forced to CLEAR, sweep counter = 0.
  - Storage array has no reset; the CLEAR sweep zeroes it.
- FSM states: IDLE, CLEAR.
  - CLEAR:
    - Each cycle writes 0 to entry[cnt]; cnt increments.
    - When cnt == DEPTH-1 that entry is cleared and the FSM goes to IDLE the next cycle. CLEAR lasts exactly DEPTH cycles.
    - busy = 1 throughout, combinationally (state == CLEAR).
  - IDLE: clr_req = 1 at a posedge -> CLEAR with cnt = 0. busy rises on the cycle after clr_req is sampled.
- During CLEAR:
  - wr_en, rd_a_en and rd_b_en are ignored: no write, valid stays 0, read data holds.
  - clr_req has no effect; the sweep is not restarted.
- Write (IDLE, wr_en = 1): entry[wr_addr] <= wr_data at the posedge. Visible to a normal read issued on the next cycle.
- Read (IDLE, rd_x_en = 1):
  - At the posedge, rd_x_data <= entry[rd_x_addr] and rd_x_valid <= 1. Latency is 1 cycle from strobe to data/valid.
  - rd_x_en = 0: rd_x_valid <= 0, rd_x_data holds its previous value; outputs are never tri-stated.
- Ports A and B are fully independent and may read the same address in the same cycle; both return identical data.
- Back-to-back reads with rd_x_en held high give valid = 1 every cycle, with new data each cycle.
- Same-cycle write and read to the same address: see Optional Feature.
- Write and clr_req in the same IDLE cycle: the write is performed, then the sweep begins next cycle and zeroes it.
- Reset asserted mid-sweep or mid-read: immediate return to reset values, then the sweep restarts from 0 after RST_N rises.
- Out-of-range addresses cannot occur (DEPTH is a power of two).

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined: a read in the same cycle as wr_en to the same address returns wr_data (write-through forwarding), per port independently.
- Not defined: such a read returns the old stored value (read-before-write). The write still completes.
- In both builds, bypass is inactive during CLEAR (reads are ignored).

Test Plan:
1. Reset release, WIDTH=16, DEPTH=16:
   - busy = 1 for exactly 16 cycles, then 0.
   - Reading all 16 entries on A returns 0x0000 each, with rd_a_valid pulsing.
2. Write 0x9070 to addr 15, next cycle rd_a_en = rd_b_en = 1 both at addr 15:
   - One cycle later both ports show 0x9070 with both valid = 1.
3. Same-cycle wr_en addr 3 data 0xBEEF and rd_a_en addr 3, old value 0x1234:
   - With the macro defined, rd_a_data = 0xBEEF.
   - Without it, rd_a_data = 0x1234; a following read returns 0xBEEF.
4. Fill entries with 0x1111..0xFFFF, pulse clr_req:
   - busy high 16 cycles; wr_en and rd_a_en asserted during the sweep produce no valid and no write.
   - All entries read 0 afterwards.
5. Assert RST_N low at sweep count 7 while rd_b_data = 0xAAAA:
   - Outputs go to 0 immediately.
   - After release, busy stays high 16 full cycles.
6. rd_a_en held high 4 cycles over addresses 0,1,2,3 holding 0xA0..0xA3:
   - rd_a_valid high 4 consecutive cycles with data 0xA0, 0xA1, 0xA2, 0xA3, then valid drops to 0 and data holds 0xA3.

Source files
------------

// File: rtl/regbank_mp.sv
// regbank_mp: DEPTH x WIDTH register bank with one write port, two independent
// registered read ports (A, B) and a sequential clear engine that sweeps every
// entry to zero after reset or on clr_req.
// Build option: define REGBANK_BYPASS_EN to forward a same-cycle write to a
// read of the same address (write-through); otherwise reads see the old value.
module regbank_mp #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr_req,
  output logic             busy,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_a_en,
  input  logic [AW-1:0]    rd_a_addr,
  output logic [WIDTH-1:0] rd_a_data,
  output logic             rd_a_valid,
  input  logic             rd_b_en,
  input  logic [AW-1:0]    rd_b_addr,
  output logic [WIDTH-1:0] rd_b_data,
  output logic             rd_b_valid
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] rd_a_data_q, rd_a_data_d;
  logic [WIDTH-1:0] rd_b_data_q, rd_b_data_d;
  logic             rd_a_valid_q, rd_a_valid_d;
  logic             rd_b_valid_q, rd_b_valid_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] rd_a_word, rd_b_word;

  // Sweep FSM: IDLE waits for clr_req, CLEAR visits every entry exactly once
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Storage write port: the sweep owns it during CLEAR, the user port otherwise
  always_comb begin
    mem_we    = wr_en;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end
  end

`ifdef REGBANK_BYPASS_EN
  // Read word selection with write-through forwarding per port
  always_comb begin
    rd_a_word = mem_q[rd_a_addr];
    rd_b_word = mem_q[rd_b_addr];
    if (wr_en && (wr_addr == rd_a_addr)) rd_a_word = wr_data;
    if (wr_en && (wr_addr == rd_b_addr)) rd_b_word = wr_data;
  end
`else
  // Read word selection, read-before-write on address collision
  always_comb begin
    rd_a_word = mem_q[rd_a_addr];
    rd_b_word = mem_q[rd_b_addr];
  end
`endif

  // Read port next state: capture only in IDLE with strobe, otherwise hold data
  always_comb begin
    rd_a_data_d  = rd_a_data_q;
    rd_b_data_d  = rd_b_data_q;
    rd_a_valid_d = 1'b0;
    rd_b_valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (rd_a_en) begin
        rd_a_data_d  = rd_a_word;
        rd_a_valid_d = 1'b1;
      end
      if (rd_b_en) begin
        rd_b_data_d  = rd_b_word;
        rd_b_valid_d = 1'b1;
      end
    end
  end

  // Control and read registers; reset lands in CLEAR so the array gets swept
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      rd_a_data_q  <= '0;
      rd_b_data_q  <= '0;
      rd_a_valid_q <= 1'b0;
      rd_b_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_a_data_q  <= rd_a_data_d;
      rd_b_data_q  <= rd_b_data_d;
      rd_a_valid_q <= rd_a_valid_d;
      rd_b_valid_q <= rd_b_valid_d;
    end
  end

  // Storage array, deliberately without reset (the sweep zeroes it)
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign busy       = (state_q == CLEAR);
  assign rd_a_data  = rd_a_data_q;
  assign rd_b_data  = rd_b_data_q;
  assign rd_a_valid = rd_a_valid_q;
  assign rd_b_valid = rd_b_valid_q;

endmodule

// File: tb/tb_regbank_mp.sv
// Testbench for regbank_mp: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the register bank.
module tb_regbank_mp;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef REGBANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             clr_req = 1'b0;
  logic             busy;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_a_en = 1'b0;
  logic [AW-1:0]    rd_a_addr = '0;
  logic [WIDTH-1:0] rd_a_data;
  logic             rd_a_valid;
  logic             rd_b_en = 1'b0;
  logic [AW-1:0]    rd_b_addr = '0;
  logic [WIDTH-1:0] rd_b_data;
  logic             rd_b_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state
  logic [WIDTH-1:0] mdl [DEPTH];
  int               clr_left;
  logic [WIDTH-1:0] exp_a, exp_b;
  logic             exp_a_vld, exp_b_vld, exp_busy;

  regbank_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .clr_req(clr_req), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data), .rd_a_valid(rd_a_valid),
    .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data), .rd_b_valid(rd_b_valid)
  );

  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    clr_req = 1'b0; wr_en = 1'b0; rd_a_en = 1'b0; rd_b_en = 1'b0;
  endtask

  // Reset puts the bank in a fresh sweep: outputs zero, array will read zero
  task automatic model_reset();
    exp_a = '0; exp_b = '0; exp_a_vld = 1'b0; exp_b_vld = 1'b0;
    clr_left = DEPTH; exp_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  // Advance one clock: predict the outputs from the current inputs, then clock
  task automatic step();
    if (clr_left == 0) begin
      exp_a_vld = rd_a_en;
      exp_b_vld = rd_b_en;
      if (rd_a_en) exp_a = (BYP && wr_en && wr_addr == rd_a_addr) ? wr_data : mdl[rd_a_addr];
      if (rd_b_en) exp_b = (BYP && wr_en && wr_addr == rd_b_addr) ? wr_data : mdl[rd_b_addr];
      if (wr_en) mdl[wr_addr] = wr_data;
      if (clr_req) begin
        clr_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      end
    end else begin
      exp_a_vld = 1'b0;
      exp_b_vld = 1'b0;
      clr_left--;
    end
    exp_busy = (clr_left != 0);
    @(posedge CLK); #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    idle_inputs(); wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    int n;
    #12;
    tests_run++;
    if (busy !== 1'b1 || rd_a_data !== '0 || rd_b_data !== '0 || rd_a_valid !== 1'b0 || rd_b_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs busy=%b a=%h b=%h va=%b vb=%b required busy=1 a=0 b=0 va=0 vb=0",
               busy, rd_a_data, rd_b_data, rd_a_valid, rd_b_valid);
    end
    model_reset();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin step(); n++; end
    tests_run++;
    if (n != DEPTH) begin
      tests_failed++;
      $display("FAIL reset_busy_len got %0d cycles required %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_a_en = 1'b1; rd_a_addr = AW'(i);
      step();
      tests_run++;
      if (rd_a_valid !== 1'b1 || rd_a_data !== 16'h0000) begin
        tests_failed++;
        $display("FAIL reset_read addr=%0d got v=%b d=%h required v=1 d=0000", i, rd_a_valid, rd_a_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_dual_read();
    write_word(4'd15, 16'h9070);
    rd_a_en = 1'b1; rd_a_addr = 4'd15; rd_b_en = 1'b1; rd_b_addr = 4'd15;
    step();
    idle_inputs();
    tests_run++;
    if (rd_a_valid !== 1'b1 || rd_b_valid !== 1'b1 || rd_a_data !== 16'h9070 || rd_b_data !== 16'h9070) begin
      tests_failed++;
      $display("FAIL dual_read got va=%b a=%h vb=%b b=%h required 1 9070 1 9070",
               rd_a_valid, rd_a_data, rd_b_valid, rd_b_data);
    end
  endtask

  task automatic test_same_cycle();
    logic [WIDTH-1:0] req;
    write_word(4'd3, 16'h1234);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
    rd_a_en = 1'b1; rd_a_addr = 4'd3;
    step();
    idle_inputs();
    req = BYP ? 16'hBEEF : 16'h1234;
    tests_run++;
    if (rd_a_valid !== 1'b1 || rd_a_data !== req) begin
      tests_failed++;
      $display("FAIL same_cycle_rw got v=%b d=%h required v=1 d=%h", rd_a_valid, rd_a_data, req);
    end
    rd_a_en = 1'b1; rd_a_addr = 4'd3;
    step();
    idle_inputs();
    tests_run++;
    if (rd_a_data !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL same_cycle_followup got %h required beef", rd_a_data);
    end
  endtask

  task automatic test_clear_request();
    int n;
    for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 16'h1111 * WIDTH'(i % 15 + 1));
    clr_req = 1'b1;
    step();
    idle_inputs();
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      wr_en = 1'b1; wr_addr = AW'($urandom_range(0, DEPTH - 1)); wr_data = 16'hDEAD;
      rd_a_en = 1'b1; rd_a_addr = AW'($urandom_range(0, DEPTH - 1));
      clr_req = 1'b1;
      step();
      n++;
      tests_run++;
      if (rd_a_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL clear_valid cycle=%0d got %b required 0", n, rd_a_valid);
      end
    end
    idle_inputs();
    tests_run++;
    if (n != DEPTH) begin
      tests_failed++;
      $display("FAIL clear_busy_len got %0d cycles required %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_a_en = 1'b1; rd_a_addr = AW'(i);
      step();
      tests_run++;
      if (rd_a_data !== 16'h0000 || rd_a_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL clear_read addr=%0d got v=%b d=%h required v=1 d=0000", i, rd_a_valid, rd_a_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    write_word(4'd5, 16'hAAAA);
    rd_b_en = 1'b1; rd_b_addr = 4'd5;
    step();
    idle_inputs();
    clr_req = 1'b1;
    step();
    idle_inputs();
    repeat (7) step();
    tests_run++;
    if (busy !== 1'b1 || rd_b_data !== 16'hAAAA) begin
      tests_failed++;
      $display("FAIL mid_sweep_hold got busy=%b b=%h required busy=1 b=aaaa", busy, rd_b_data);
    end
    RST_N = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (rd_b_data !== '0 || rd_a_data !== '0 || rd_b_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_sweep_reset got a=%h b=%h vb=%b busy=%b required 0 0 0 1",
               rd_a_data, rd_b_data, rd_b_valid, busy);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin step(); n++; end
    tests_run++;
    if (n != DEPTH) begin
      tests_failed++;
      $display("FAIL mid_sweep_busy_len got %0d cycles required %0d", n, DEPTH);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) write_word(AW'(i), 16'h00A0 + WIDTH'(i));
    for (int i = 0; i < 4; i++) begin
      rd_a_en = 1'b1; rd_a_addr = AW'(i);
      step();
      tests_run++;
      if (rd_a_valid !== 1'b1 || rd_a_data !== 16'h00A0 + WIDTH'(i)) begin
        tests_failed++;
        $display("FAIL b2b_read idx=%0d got v=%b d=%h required v=1 d=%h",
                 i, rd_a_valid, rd_a_data, 16'h00A0 + WIDTH'(i));
      end
    end
    idle_inputs();
    step();
    tests_run++;
    if (rd_a_valid !== 1'b0 || rd_a_data !== 16'h00A3) begin
      tests_failed++;
      $display("FAIL b2b_hold got v=%b d=%h required v=0 d=00a3", rd_a_valid, rd_a_data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      wr_data   = WIDTH'($urandom);
      rd_a_en   = ($urandom_range(0, 2) != 0);
      rd_a_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
      rd_b_en   = ($urandom_range(0, 2) != 0);
      rd_b_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
      clr_req   = ($urandom_range(0, 59) == 0);
      step();
      tests_run++;
      if (rd_a_data !== exp_a || rd_a_valid !== exp_a_vld || rd_b_data !== exp_b ||
          rd_b_valid !== exp_b_vld || busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got a=%h va=%b b=%h vb=%b busy=%b required a=%h va=%b b=%h vb=%b busy=%b",
                 c, rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, busy,
                 exp_a, exp_a_vld, exp_b, exp_b_vld, exp_busy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_dual_read();
    test_same_cycle();
    test_clear_request();
    test_reset_mid_sweep();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
